// File: rtl/score_display.sv
// Score stage: BCD accumulator fed by line-clear events,
// rendered as four seven-segment digits for the VGA top.
module score_display #(
  parameter int         X0    = 560,
  parameter int         Y0    = 40,
  parameter int         PITCH = 20,
  parameter logic [7:0] COLOR = 8'hFC
) (
  input  logic        vclk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        lines_valid,
  input  logic [2:0]  lines_count,
  input  logic        clear_score,
  output logic [7:0]  pixel_score,
  output logic [15:0] score_bcd,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, ADD, SAT, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  carry_q, carry_d;
  logic [15:0] score_q, score_d;
  logic        ovf_q, ovf_d;
  logic        pend_v_q, pend_v_d;
  logic [3:0]  pend_pts_q, pend_pts_d;
  logic [15:0] shown_q, shown_d;
  logic [7:0]  pix_q, pix_d;

  logic [3:0]  new_pts;
  logic        ev;
  logic [3:0]  digit;
  logic [4:0]  sum;
  logic        wrap;

  function automatic logic [3:0] pts_of(input logic [2:0] n);
    unique case (n)
      3'd1:    pts_of = 4'd1;
      3'd2:    pts_of = 4'd3;
      3'd3:    pts_of = 4'd5;
      3'd4:    pts_of = 4'd8;
      default: pts_of = 4'd0;
    endcase
  endfunction

  // {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    unique case (d)
      4'd0:    seg_pat = 7'b1111110;
      4'd1:    seg_pat = 7'b0110000;
      4'd2:    seg_pat = 7'b1101101;
      4'd3:    seg_pat = 7'b1111001;
      4'd4:    seg_pat = 7'b0110011;
      4'd5:    seg_pat = 7'b1011011;
      4'd6:    seg_pat = 7'b1011111;
      4'd7:    seg_pat = 7'b1110000;
      4'd8:    seg_pat = 7'b1111111;
      4'd9:    seg_pat = 7'b1111011;
      default: seg_pat = 7'b0000000;
    endcase
  endfunction

  function automatic logic seg_hit(
    input logic [3:0] lx,
    input logic [4:0] ly,
    input logic [6:0] p
  );
    logic mid_x;
    mid_x = (lx >= 4'd2) && (lx <= 4'd13);
    seg_hit =
      (p[6] && ly <= 5'd2 && mid_x) ||
      (p[5] && lx >= 4'd13 && ly >= 5'd2 && ly <= 5'd11) ||
      (p[4] && lx >= 4'd13 && ly >= 5'd12 && ly <= 5'd21) ||
      (p[3] && ly >= 5'd21 && mid_x) ||
      (p[2] && lx <= 4'd2 && ly >= 5'd12 && ly <= 5'd21) ||
      (p[1] && lx <= 4'd2 && ly >= 5'd2 && ly <= 5'd11) ||
      (p[0] && ly >= 5'd11 && ly <= 5'd12 && mid_x);
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    score_d    = score_q;
    ovf_d      = ovf_q;
    pend_v_d   = pend_v_q;
    pend_pts_d = pend_pts_q;
    new_pts    = pts_of(lines_count);
    ev         = lines_valid && (new_pts != 4'd0);
    digit      = score_q[{idx_q, 2'b00} +: 4];
    sum        = {1'b0, digit} + {1'b0, carry_q};
    wrap       = sum > 5'd9;

    unique case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          carry_d    = pend_pts_q;
          idx_d      = 2'd0;
          state_d    = ADD;
          pend_v_d   = ev;
          pend_pts_d = ev ? new_pts : pend_pts_q;
        end else if (ev) begin
          carry_d = new_pts;
          idx_d   = 2'd0;
          state_d = ADD;
        end
      end
      ADD: begin
        score_d[{idx_q, 2'b00} +: 4] =
          wrap ? 4'(sum - 5'd10) : sum[3:0];
        carry_d = {3'b000, wrap};
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3)
          state_d = wrap ? SAT : DONE;
      end
      SAT: begin
        score_d = 16'h9999;
        ovf_d   = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // One-deep queue for events arriving while the adder is occupied
    if (state_q != IDLE && ev && !pend_v_q) begin
      pend_v_d   = 1'b1;
      pend_pts_d = new_pts;
    end

    shown_d = (hcount == 11'd0 && vcount == 10'd0) ? score_q : shown_q;

    if (clear_score) begin
      state_d  = IDLE;
      idx_d    = 2'd0;
      carry_d  = 4'd0;
      score_d  = 16'h0000;
      ovf_d    = 1'b0;
      pend_v_d = 1'b0;
      shown_d  = 16'h0000;
    end
  end

  logic [10:0] ly, lx, ox;
  logic        in_y, lit;
  logic [3:0]  show;

  always_comb begin
    lit  = 1'b0;
    lx   = 11'd0;
    ox   = 11'd0;
    ly   = {1'b0, vcount} - 11'(Y0);
    in_y = ({1'b0, vcount} >= 11'(Y0)) && (ly < 11'd24);
    show = {|shown_q[15:12], |shown_q[15:8], |shown_q[15:4], 1'b1};
    for (int k = 0; k < 4; k++) begin
      ox = 11'(X0 + (3 - k) * PITCH);
      lx = hcount - ox;
      if (in_y && show[k] && hcount >= ox && lx < 11'd16 &&
          seg_hit(lx[3:0], ly[4:0], seg_pat(shown_q[4*k +: 4])))
        lit = 1'b1;
    end
    pix_d = (lit && hcount < 11'd800 && vcount < 10'd600) ? COLOR : 8'h00;
  end

  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      carry_q    <= 4'd0;
      score_q    <= 16'h0000;
      ovf_q      <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_pts_q <= 4'd0;
      shown_q    <= 16'h0000;
      pix_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      score_q    <= score_d;
      ovf_q      <= ovf_d;
      pend_v_q   <= pend_v_d;
      pend_pts_q <= pend_pts_d;
      shown_q    <= shown_d;
      pix_q      <= pix_d;
    end
  end

  assign pixel_score = pix_q;
  assign score_bcd   = score_q;
  assign busy        = (state_q == ADD) || (state_q == SAT);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: pixel vector table plus
// hand-written event, pending, clear, saturation and reset sequences.
module tb_score_display;

  logic        vclk = 1'b0;
  logic        rst_n;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        lv;
  logic [2:0]  lc;
  logic        clr;
  logic [7:0]  pix;
  logic [15:0] score;
  logic        busy;
  logic        ovf;

  localparam logic [7:0] C = 8'hFC;

  score_display dut (
    .vclk        (vclk),
    .rst_n       (rst_n),
    .hcount      (hc),
    .vcount      (vc),
    .lines_valid (lv),
    .lines_count (lc),
    .clear_score (clr),
    .pixel_score (pix),
    .score_bcd   (score),
    .busy        (busy),
    .overflow    (ovf)
  );

  always #10 vclk = ~vclk;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic [7:0]  px;
  } pv_t;

  pv_t tbl[29];
  int  nvec = 0;
  int  nerr = 0;

  function automatic pv_t mk(input int h, input int v, input logic [7:0] p);
    pv_t t;
    t.h  = 11'(h);
    t.v  = 10'(v);
    t.px = p;
    return t;
  endfunction

  task automatic step();
    @(posedge vclk);
    @(negedge vclk);
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_pix(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      hc = tbl[i].h;
      vc = tbl[i].v;
      step();
      chk($sformatf("pix[%0d]", i), {8'h00, pix}, {8'h00, tbl[i].px});
    end
  endtask

  task automatic frame();
    hc = 11'd0;
    vc = 10'd0;
    step();
    hc = 11'd1000;
    vc = 10'd650;
  endtask

  task automatic ev(input logic [2:0] c);
    lv = 1'b1;
    lc = c;
    step();
    lv = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    // score 0: digit 0 at x=620 shows a..f, nothing else
    tbl[0]  = mk(625, 41, C);
    tbl[1]  = mk(634, 45, C);
    tbl[2]  = mk(634, 55, C);
    tbl[3]  = mk(625, 62, C);
    tbl[4]  = mk(621, 55, C);
    tbl[5]  = mk(621, 45, C);
    tbl[6]  = mk(625, 51, 8'h00);
    tbl[7]  = mk(627, 47, 8'h00);
    tbl[8]  = mk(636, 45, 8'h00);
    tbl[9]  = mk(619, 45, 8'h00);
    tbl[10] = mk(625, 39, 8'h00);
    tbl[11] = mk(625, 64, 8'h00);
    tbl[12] = mk(605, 41, 8'h00);
    tbl[13] = mk(900, 41, 8'h00);
    // score changed to 0011, frame not yet latched
    tbl[14] = mk(625, 41, C);
    tbl[15] = mk(614, 45, 8'h00);
    // shown 0011
    tbl[16] = mk(625, 41, 8'h00);
    tbl[17] = mk(634, 45, C);
    tbl[18] = mk(634, 55, C);
    tbl[19] = mk(621, 45, 8'h00);
    tbl[20] = mk(614, 45, C);
    tbl[21] = mk(605, 62, 8'h00);
    tbl[22] = mk(594, 45, 8'h00);
    // shown 9999, digit 3 at x=560
    tbl[23] = mk(565, 62, C);
    tbl[24] = mk(561, 55, 8'h00);
    tbl[25] = mk(565, 51, C);
    tbl[26] = mk(561, 45, C);
    // after clear_score
    tbl[27] = mk(625, 41, C);
    tbl[28] = mk(614, 45, 8'h00);

    rst_n = 1'b0;
    hc    = 11'd1000;
    vc    = 10'd650;
    lv    = 1'b0;
    lc    = 3'd0;
    clr   = 1'b0;
    @(negedge vclk);
    @(negedge vclk);
    chk("rst_score", score, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_ovf", {15'd0, ovf}, 16'd0);
    chk("rst_pix", {8'h00, pix}, 16'h0000);
    rst_n = 1'b1;
    step();

    frame();
    run_pix(0, 13);

    // back-to-back events: second queued, third dropped
    lv = 1'b1;
    lc = 3'd4;
    step();
    chk("busy_on", {15'd0, busy}, 16'd1);
    lc = 3'd2;
    step();
    lc = 3'd3;
    step();
    lv = 1'b0;
    step();
    step();
    chk("lat5_score", score, 16'h0008);
    chk("lat5_busy", {15'd0, busy}, 16'd0);
    repeat (8) step();
    chk("pend_score", score, 16'h0011);
    chk("pend_busy", {15'd0, busy}, 16'd0);

    run_pix(14, 15);
    frame();
    run_pix(16, 22);

    // clear during ADD with a pending event
    lv = 1'b1;
    lc = 3'd1;
    step();
    lc = 3'd2;
    step();
    lv  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_score", score, 16'h0000);
    chk("clr_busy", {15'd0, busy}, 16'd0);
    chk("clr_ovf", {15'd0, ovf}, 16'd0);
    repeat (10) step();
    chk("clr_hold", score, 16'h0000);
    run_pix(27, 28);

    // illegal counts are ignored
    lv = 1'b1;
    lc = 3'd0;
    step();
    lc = 3'd5;
    step();
    lc = 3'd7;
    step();
    lv = 1'b0;
    chk("ign_busy", {15'd0, busy}, 16'd0);
    repeat (6) step();
    chk("ign_score", score, 16'h0000);

    // preload 9995 = 1249*8 + 3
    for (int i = 0; i < 1249; i++) ev(3'd4);
    ev(3'd2);
    chk("pre_score", score, 16'h9995);
    chk("pre_ovf", {15'd0, ovf}, 16'd0);
    ev(3'd4);
    chk("sat_score", score, 16'h9999);
    chk("sat_ovf", {15'd0, ovf}, 16'd1);
    ev(3'd1);
    chk("sat2_score", score, 16'h9999);
    chk("sat2_ovf", {15'd0, ovf}, 16'd1);
    frame();
    run_pix(23, 26);

    // asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #2;
    chk("arst_score", score, 16'h0000);
    chk("arst_ovf", {15'd0, ovf}, 16'd0);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_pix", {8'h00, pix}, 16'h0000);
    @(negedge vclk);
    rst_n = 1'b1;
    step();
    ev(3'd3);
    chk("resume_score", score, 16'h0005);
    chk("resume_ovf", {15'd0, ovf}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
